// File: rtl/alu_pkg.sv
// Shared types for the ALU control / multiply-divide block: ALU encodings, decode classes,
// M-extension func3 codes and sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_NE   = 4'b1010,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic [1:0] {OP_LDST, OP_BR, OP_RTYPE, OP_ITYPE} alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} mdu_state_e;

  // Shared R/I arithmetic decode; only R-type may turn func3=000 into SUB.
  function automatic alu_ctrl_e arith_ctrl(logic [2:0] f3, logic f7_5, logic allow_sub);
    case (f3)
      3'b000:  return (allow_sub && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_mdu_core.sv
// One iteration of the multiply/divide datapath: shift-add multiply step or restoring divide step.
// The divide step exists only when M_DIV_EN is defined.
module alu_mdu_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;

  // {hi,lo} holds partial product over remaining multiplier bits; shift right each step
  assign sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);

`ifdef M_DIV_EN
  logic [XLEN:0] rs;
  logic [XLEN:0] diff;

  // hi is the partial remainder, lo shifts dividend bits out and quotient bits in
  assign rs   = {hi_i, lo_i[XLEN-1]};
  assign diff = rs - {1'b0, b_i};

  always_comb begin
    if (is_div_i) begin
      hi_o = diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end
`else
  logic unused_div;
  assign unused_div = is_div_i;
  assign hi_o       = sum[XLEN:1];
  assign lo_o       = {sum[0], lo_i[XLEN-1:1]};
`endif

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// RV32I ALU control decode plus RV32M iterative multiply/divide sequencer with valid/ready stall.
// Define M_DIV_EN to build the divider; otherwise DIV/REM ops complete immediately with mdu_err.
module alu_ctrl_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      func3,
  input  logic            func7_5,
  input  logic            func7_0,
  input  logic            in_valid,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            in_ready,
  output logic [3:0]      alu_ctrl,
  output logic            use_mdu,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            mdu_err
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl    = ALU_ADD;
    use_mdu = 1'b0;
    case (alu_op_e'(alu_op))
      OP_BR: begin
        case (func3)
          3'b000:         ctrl = ALU_SUB;
          3'b001:         ctrl = ALU_NE;
          3'b100, 3'b101: ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl = ALU_SLTU;
          default:        ctrl = ALU_ADD;
        endcase
      end
      OP_RTYPE: begin
        if (func7_0) use_mdu = 1'b1;
        else         ctrl    = arith_ctrl(func3, func7_5, 1'b1);
      end
      OP_ITYPE: ctrl = arith_ctrl(func3, func7_5, 1'b0);
      default:  ctrl = ALU_ADD;
    endcase
  end

  assign alu_ctrl = ctrl;

  mdu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;
  logic            out_valid_q;
  logic            err_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, hi_n, lo_n;
  mdu_op_e         op_q;
  logic            div_q, neg_p_q, neg_r_q;

  mdu_op_e         op_in;
  logic            accept, a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign mdu_err   = err_q;

  assign accept = in_valid & in_ready & use_mdu;
  assign op_in  = mdu_op_e'(func3);
  assign a_sgn  = (op_in == MDU_MULH) || (op_in == MDU_MULHSU) ||
                  (op_in == MDU_DIV)  || (op_in == MDU_REM);
  assign b_sgn  = (op_in == MDU_MULH) || (op_in == MDU_DIV) || (op_in == MDU_REM);
  assign sa     = a_sgn & op_a[XLEN-1];
  assign sb     = b_sgn & op_b[XLEN-1];
  assign mag_a  = sa ? -op_a : op_a;
  assign mag_b  = sb ? -op_b : op_b;

`ifdef M_DIV_EN
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] min_val;
  assign min_val  = {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (op_b == '0);
  assign div_ovf  = !func3[0] && (op_a == min_val) && (&op_b);
`endif

  // Unsigned magnitudes are computed in the core; signs are restored here on the last step.
  function automatic logic [XLEN-1:0] fixup(mdu_op_e op, logic [XLEN-1:0] hi,
                                            logic [XLEN-1:0] lo, logic neg_p, logic neg_r);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, r;
    p = neg_p ? -{hi, lo} : {hi, lo};
    q = neg_p ? -lo : lo;
    r = neg_r ? -hi : hi;
    case (op)
      MDU_MUL:                          return p[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: return p[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                return q;
      default:                          return r;
    endcase
  endfunction

  alu_mdu_core #(.XLEN(XLEN)) u_core (
    .is_div_i (div_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (hi_n),
    .lo_o     (lo_n)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (accept) begin
`ifdef M_DIV_EN
            if (func3[2] && div_zero) begin
              result_q    <= func3[1] ? op_a : '1;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else if (func3[2] && div_ovf) begin
              result_q    <= func3[1] ? '0 : min_val;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
`else
            if (func3[2]) begin
              result_q    <= '0;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
`endif
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            result_q    <= fixup(op_q, hi_n, lo_n, neg_p_q, neg_r_q);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        default: begin
          err_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Operand/partial registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_in;
      div_q   <= func3[2];
      neg_p_q <= sa ^ sb;
      neg_r_q <= sa;
      hi_q    <= '0;
      lo_q    <= mag_a;
      b_q     <= mag_b;
    end else if (state_q == ST_CALC) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

endmodule
